data_mem_port: RTL

Data-memory access stage of the pipeline's MEM stage, directly upstream of the load truncation unit. Holds a 4 KB word-organised synchronous RAM. Executes loads in one cycle and returns the raw 32-bit word, address and opcode to the truncation unit. Executes word stores in one cycle and byte/halfword stores as a two-cycle read-modify-write, stalling upstream through `ready`.

---
 rtl/data_mem_port.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/data_mem_port.sv
`default_nettype none
// ============================================================================
// data_mem_port: MEM-stage word RAM; 1-cycle loads/word stores, 2-cycle sub-word RMW.
// Optional macro ALIGN_CHECK_EN suppresses misaligned accesses and pulses error. Rev 1.0
// ============================================================================
module data_mem_port #(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [2:0]        opcode,
  input  logic [ADDR_W-1:0] direccion,
  input  logic [31:0]       datoEscritura,
  output logic              ready,
  output logic              valid_out,
  output logic [31:0]       salida,
  output logic [ADDR_W-1:0] direccionOut,
  output logic [2:0]        opcodeOut,
  output logic              error
);

  localparam int DEPTH = 1 << (ADDR_W - 2);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RMW_RD = 2'd1;
  localparam logic [1:0] S_RMW_WR = 2'd2;

  logic [31:0]       mem_q [DEPTH];
  logic [1:0]        state_q, state_d;
  logic [31:0]       merge_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       data_q;
  logic              is_byte_q;
  logic              valid_q;
  logic [31:0]       salida_q;
  logic [ADDR_W-1:0] dir_out_q;
  logic [2:0]        op_out_q;

  logic              w_accept;
  logic              w_is_byte;
  logic              w_is_word;
  logic              w_misaligned;
  logic              w_do_load;
  logic              w_do_word_wr;
  logic              w_do_sub_wr;
  logic [ADDR_W-3:0] w_idx;
  logic [ADDR_W-3:0] w_rmw_idx;
  logic [31:0]       w_merged;

  assign ready     = (state_q == S_IDLE);
  assign w_accept  = req && ready;
  assign w_is_byte = (opcode[1:0] == 2'b00);
  assign w_is_word = opcode[1];
  assign w_idx     = direccion[ADDR_W-1:2];
  assign w_rmw_idx = addr_q[ADDR_W-1:2];

`ifdef ALIGN_CHECK_EN
  assign w_misaligned = ((opcode[1:0] == 2'b01) && direccion[0]) ||
                        (w_is_word && (direccion[1:0] != 2'b00));
`else
  assign w_misaligned = 1'b0;
`endif

  assign w_do_load    = w_accept && !we && !w_misaligned;
  assign w_do_word_wr = w_accept && we && w_is_word && !w_misaligned;
  assign w_do_sub_wr  = w_accept && we && !w_is_word && !w_misaligned;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (w_do_sub_wr) state_d = S_RMW_RD;
      S_RMW_RD: state_d = S_RMW_WR;
      S_RMW_WR: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Only the addressed lane of the fetched word is replaced by the latched data.
  always_comb begin
    w_merged = merge_q;
    if (is_byte_q) begin
      w_merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    end else begin
      w_merged[{addr_q[1], 4'b0000} +: 16] = data_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      is_byte_q <= 1'b0;
      valid_q   <= 1'b0;
      salida_q  <= '0;
      dir_out_q <= '0;
      op_out_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= w_do_load;
      if (w_do_load) begin
        salida_q  <= mem_q[w_idx];
        dir_out_q <= direccion;
        op_out_q  <= opcode;
      end
      if (w_do_sub_wr) begin
        addr_q    <= direccion;
        data_q    <= datoEscritura[15:0];
        is_byte_q <= w_is_byte;
      end
    end
  end

  // Write enables key off the reset-cleared state, so a reset mid-RMW drops the write.
  always_ff @(posedge clk) begin
    if (rst_n && w_do_word_wr) begin
      mem_q[w_idx] <= datoEscritura;
    end else if (state_q == S_RMW_WR) begin
      mem_q[w_rmw_idx] <= w_merged;
    end
    if (state_q == S_RMW_RD) begin
      merge_q <= mem_q[w_rmw_idx];
    end
  end

`ifdef ALIGN_CHECK_EN
  logic error_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= w_accept && w_misaligned;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

  assign valid_out    = valid_q;
  assign salida       = salida_q;
  assign direccionOut = dir_out_q;
  assign opcodeOut    = op_out_q;

endmodule
`default_nettype wire
